// File: rtl/mvm_result_drain.sv
// rtl/mvm_result_drain.sv - result vector FIFO and lane serializer after the MVM engine
//
// Ports:
//   clk, rst        single clock; asynchronous active-high reset
//   i_result        parallel result vector (NUM_OLANES words of OWIDTH bits)
//   i_valid         one-cycle strobe: i_result holds a complete vector
//   o_data          current output lane word (0 while o_valid is low)
//   o_lane          lane index of o_data
//   o_last          o_data is the final lane of its vector
//   o_valid         o_data/o_lane/o_last valid
//   i_ready         consumer accepts the presented word this cycle
//   o_count         buffered vectors, including the one being drained
//   o_full          o_count == DEPTH
//   o_overflow      sticky: at least one vector was dropped since reset

module mvm_result_drain #(
    parameter int OWIDTH     = 32,
    parameter int NUM_OLANES = 8,
    parameter int DEPTH      = 4,
    parameter int LANEW      = $clog2(NUM_OLANES),
    parameter int CNTW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OWIDTH-1:0] i_result [0:NUM_OLANES-1],
    input  logic              i_valid,
    output logic [OWIDTH-1:0] o_data,
    output logic [LANEW-1:0]  o_lane,
    output logic              o_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CNTW-1:0]   o_count,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int              PTRW      = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);
    localparam logic [LANEW-1:0] LAST_LANE = LANEW'(NUM_OLANES - 1);

    // Vector storage: one row per buffered vector, all lanes written together.
    logic [OWIDTH-1:0] mem [0:DEPTH-1][0:NUM_OLANES-1];

    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [LANEW-1:0] lane;
    logic [CNTW-1:0]  count;
    logic             overflow;

    logic valid;
    logic beat;
    logic pop;
    logic push;
    logic drop;

    assign valid = (count != '0);
    assign beat  = valid & i_ready;
    // A vector leaves the buffer when its last lane is transferred.
    assign pop   = beat & (lane == LAST_LANE);
    // A full buffer still accepts a vector in the cycle its head row is freed;
    // the write lands on the row being read, which is safe because the read
    // of that row completes in this same cycle.
    assign push  = i_valid & ((count != FULL_CNT) | pop);
    assign drop  = i_valid & (count == FULL_CNT) & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lane     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            if (beat) begin
                lane <= pop ? '0 : lane + LANEW'(1);
            end
            if (push && !pop) begin
                count <= count + CNTW'(1);
            end else if (pop && !push) begin
                count <= count - CNTW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: rows are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int l = 0; l < NUM_OLANES; l++) begin
                mem[wr_ptr][l] <= i_result[l];
            end
        end
    end

    // Outputs derive only from registered state, so they stay stable while
    // the consumer stalls and drop to zero the moment reset asserts.
    assign o_valid    = valid;
    assign o_data     = valid ? mem[rd_ptr][lane] : '0;
    assign o_lane     = valid ? lane : '0;
    assign o_last     = valid & (lane == LAST_LANE);
    assign o_count    = count;
    assign o_full     = (count == FULL_CNT);
    assign o_overflow = overflow;

endmodule

// File: tb/tb_mvm_result_drain.sv
// tb/tb_mvm_result_drain.sv - directed self-checking bench for mvm_result_drain

module tb_mvm_result_drain;

    localparam int OWIDTH     = 32;
    localparam int NUM_OLANES = 8;
    localparam int DEPTH      = 4;
    localparam int LANEW      = 3;
    localparam int CNTW       = 3;

    logic              clk;
    logic              rst;
    logic [OWIDTH-1:0] i_result [0:NUM_OLANES-1];
    logic              i_valid;
    logic [OWIDTH-1:0] o_data;
    logic [LANEW-1:0]  o_lane;
    logic              o_last;
    logic              o_valid;
    logic              i_ready;
    logic [CNTW-1:0]   o_count;
    logic              o_full;
    logic              o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mvm_result_drain #(
        .OWIDTH(OWIDTH), .NUM_OLANES(NUM_OLANES), .DEPTH(DEPTH),
        .LANEW(LANEW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .i_result(i_result), .i_valid(i_valid),
        .o_data(o_data), .o_lane(o_lane), .o_last(o_last), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count), .o_full(o_full),
        .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] base;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  el;
        logic        elast;
        logic [2:0]  ecnt;
        logic        efull;
        logic        eovf;
    } vec_t;

    vec_t tbl [0:31];
    int   n_rows = 0;

    task automatic add(input logic v, input logic [31:0] base, input logic r,
                       input logic ev, input logic [31:0] ed, input logic [2:0] el,
                       input logic elast, input logic [2:0] ecnt);
        tbl[n_rows] = '{v, base, r, ev, ed, el, elast, ecnt, 1'b0, 1'b0};
        n_rows++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input logic [31:0] base);
        for (int l = 0; l < NUM_OLANES; l++) i_result[l] = base + 32'(l);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [31:0] ed,
                             input logic [2:0] el, input logic elast, input logic [2:0] ecnt,
                             input logic efull, input logic eovf);
        chk({tag, "_valid"}, 32'(o_valid), 32'(ev));
        chk({tag, "_data"}, o_data, ed);
        chk({tag, "_lane"}, 32'(o_lane), 32'(el));
        chk({tag, "_last"}, 32'(o_last), 32'(elast));
        chk({tag, "_count"}, 32'(o_count), 32'(ecnt));
        chk({tag, "_full"}, 32'(o_full), 32'(efull));
        chk({tag, "_ovf"}, 32'(o_overflow), 32'(eovf));
    endtask

    // Checks the presented word against base+lane, then transfers it.
    task automatic drain_vec(input string tag, input logic [31:0] base);
        i_ready = 1'b1;
        for (int l = 0; l < NUM_OLANES; l++) begin
            chk($sformatf("%s_v_l%0d", tag, l), 32'(o_valid), 32'd1);
            chk($sformatf("%s_d_l%0d", tag, l), o_data, base + 32'(l));
            chk($sformatf("%s_ln_l%0d", tag, l), 32'(o_lane), 32'(l));
            chk($sformatf("%s_lst_l%0d", tag, l), 32'(o_last), 32'(l == NUM_OLANES - 1));
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        set_vec(32'h0);
        step();
        step();
        check_out("reset", 0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single vector, consumer always ready.
        add(1, 32'h10, 1, 1, 32'h10, 0, 0, 1);
        add(0, 32'h0,  1, 1, 32'h11, 1, 0, 1);
        add(0, 32'h0,  1, 1, 32'h12, 2, 0, 1);
        add(0, 32'h0,  1, 1, 32'h13, 3, 0, 1);
        add(0, 32'h0,  1, 1, 32'h14, 4, 0, 1);
        add(0, 32'h0,  1, 1, 32'h15, 5, 0, 1);
        add(0, 32'h0,  1, 1, 32'h16, 6, 0, 1);
        add(0, 32'h0,  1, 1, 32'h17, 7, 1, 1);
        add(0, 32'h0,  1, 0, 32'h0,  0, 0, 0);
        // Same shape of vector with the consumer stalling intermittently.
        add(1, 32'h20, 0, 1, 32'h20, 0, 0, 1);
        add(0, 32'h0,  1, 1, 32'h21, 1, 0, 1);
        add(0, 32'h0,  0, 1, 32'h21, 1, 0, 1);
        add(0, 32'h0,  0, 1, 32'h21, 1, 0, 1);
        add(0, 32'h0,  1, 1, 32'h22, 2, 0, 1);
        add(0, 32'h0,  1, 1, 32'h23, 3, 0, 1);
        add(0, 32'h0,  0, 1, 32'h23, 3, 0, 1);
        add(0, 32'h0,  1, 1, 32'h24, 4, 0, 1);
        add(0, 32'h0,  0, 1, 32'h24, 4, 0, 1);
        add(0, 32'h0,  1, 1, 32'h25, 5, 0, 1);
        add(0, 32'h0,  1, 1, 32'h26, 6, 0, 1);
        add(0, 32'h0,  0, 1, 32'h26, 6, 0, 1);
        add(0, 32'h0,  1, 1, 32'h27, 7, 1, 1);
        add(0, 32'h0,  0, 1, 32'h27, 7, 1, 1);
        add(0, 32'h0,  1, 0, 32'h0,  0, 0, 0);

        for (int i = 0; i < n_rows; i++) begin
            i_valid = tbl[i].v;
            set_vec(tbl[i].base);
            i_ready = tbl[i].r;
            step();
            check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el,
                      tbl[i].elast, tbl[i].ecnt, tbl[i].efull, tbl[i].eovf);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;

        // Five strobes into a stalled buffer: the fifth is dropped.
        for (int k = 1; k <= 5; k++) begin
            i_valid = 1'b1;
            set_vec(32'(k) << 8);
            step();
            check_out($sformatf("ovf_push%0d", k), 1, 32'h100, 0, 0,
                      3'(k > 4 ? 4 : k), k >= 4, k == 5);
        end
        i_valid = 1'b0;
        drain_vec("ovf_v1", 32'h100);
        drain_vec("ovf_v2", 32'h200);
        drain_vec("ovf_v3", 32'h300);
        drain_vec("ovf_v4", 32'h400);
        check_out("ovf_empty", 0, 32'h0, 0, 0, 0, 0, 1);

        // Full buffer, new strobe coincident with the last-lane transfer.
        do_reset();
        check_out("rst2", 0, 32'h0, 0, 0, 0, 0, 0);
        i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1;
            set_vec(32'(k) << 12);
            step();
        end
        i_valid = 1'b0;
        check_out("full4", 1, 32'h1000, 0, 0, 4, 1, 0);
        i_ready = 1'b1;
        for (int k = 0; k < 7; k++) step();
        check_out("full_lane7", 1, 32'h1007, 7, 1, 4, 1, 0);
        i_valid = 1'b1;
        set_vec(32'h5000);
        step();
        i_valid = 1'b0;
        check_out("full_swap", 1, 32'h2000, 0, 0, 4, 1, 0);
        drain_vec("swap_v2", 32'h2000);
        drain_vec("swap_v3", 32'h3000);
        drain_vec("swap_v4", 32'h4000);
        drain_vec("swap_v5", 32'h5000);
        check_out("swap_empty", 0, 32'h0, 0, 0, 0, 0, 0);

        // Twelve vectors, one strobe every 8 cycles: a contiguous 96-word stream.
        i_ready = 1'b1;
        for (int e = 0; e <= 96; e++) begin
            i_valid = (e % 8 == 0) && (e < 96);
            set_vec(32'h0001_0000 * 32'(e / 8 + 1));
            step();
            if (e < 96) begin
                chk($sformatf("burst_v%0d", e), 32'(o_valid), 32'd1);
                chk($sformatf("burst_d%0d", e), o_data,
                    32'h0001_0000 * 32'(e / 8 + 1) + 32'(e % 8));
                chk($sformatf("burst_ln%0d", e), 32'(o_lane), 32'(e % 8));
                chk($sformatf("burst_cnt_le2_%0d", e), 32'(o_count <= 2), 32'd1);
            end else begin
                check_out("burst_end", 0, 32'h0, 0, 0, 0, 0, 0);
            end
        end
        i_valid = 1'b0;

        // Reset mid-drain at lane 3 with two vectors buffered.
        i_ready = 1'b0;
        i_valid = 1'b1;
        set_vec(32'hA0);
        step();
        set_vec(32'hB0);
        step();
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check_out("pre_rst", 1, 32'hA3, 3, 0, 2, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 32'h0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b1;
        set_vec(32'hC0);
        step();
        i_valid = 1'b0;
        check_out("post_rst", 1, 32'hC0, 0, 0, 1, 0, 0);
        drain_vec("post_rst_v", 32'hC0);
        check_out("post_rst_empty", 0, 32'h0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mvm_result_drain.md
# mvm_result_drain

Output buffer and serializer downstream of the matrix-vector multiply engine. Captures each completed result vector (NUM_OLANES lane words, presented in parallel for one cycle with a valid strobe), holds up to DEPTH vectors in a FIFO, and streams them out one OWIDTH word per cycle over a valid/ready handshake. The engine has no backpressure, so this block absorbs bursts, reports fullness to the host sequencer, and flags dropped vectors.

## Interface
Parameters:
- OWIDTH, 32, width of one lane result word
- NUM_OLANES, 8, lane words per result vector (≥2)
- DEPTH, 4, result vectors buffered; power of two, ≥2
- LANEW, $clog2(NUM_OLANES), lane index width
- CNTW, $clog2(DEPTH+1), occupancy count width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- i_result  in  [OWIDTH-1:0] x [0:NUM_OLANES-1]  parallel result vector from the engine
- i_valid  in  1  one-cycle strobe: i_result holds a complete vector
- o_data  out  OWIDTH  current output lane word
- o_lane  out  LANEW  lane index of o_data
- o_last  out  1  o_data is lane NUM_OLANES-1 of its vector
- o_valid  out  1  o_data/o_lane/o_last valid
- i_ready  in  1  consumer accepts the word this cycle
- o_count  out  CNTW  number of buffered vectors, including the one being drained
- o_full  out  1  o_count == DEPTH
- o_overflow  out  1  sticky: at least one vector was dropped

## Operation
- Storage: DEPTH entries of NUM_OLANES x OWIDTH; write pointer, read pointer (log2 DEPTH bits each, natural wrap DEPTH-1 -> 0), occupancy counter, lane counter.
- Push: i_valid high and (count < DEPTH or pop this cycle) -> write i_result to entry at write pointer, advance write pointer. All lanes captured in the same cycle.
- Drop: i_valid high, count == DEPTH, no pop this cycle -> vector discarded, pointers/count unchanged, o_overflow set to 1. Cleared only by rst.
- Output: o_valid = (count != 0). o_data = entry[read pointer][lane counter]; o_lane = lane counter; o_last = o_valid and lane counter == NUM_OLANES-1.
- Beat: o_valid and i_ready -> word transferred. If lane counter < NUM_OLANES-1, lane counter +1. Else lane counter -> 0, pop: read pointer +1.
- Count: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Handshake rules: o_valid never drops without a transfer while count != 0; o_data/o_lane/o_last stable while o_valid high and i_ready low; i_ready may be asserted with o_valid low (no effect).
- Words leave in order: vector order of acceptance, lane 0 first within each vector.
- When o_valid is low, o_data = 0, o_lane = 0, o_last = 0.
- Arithmetic: no transformation of data; words pass bit-exact.

## Timing
- Reset (asynchronous assert, released synchronously by caller): pointers, lane counter, count = 0; o_valid 0, o_data 0, o_lane 0, o_last 0, o_count 0, o_full 0, o_overflow 0. Buffered contents discarded; a mid-stream vector is abandoned, and the next vector after release begins at lane 0.
- Latency: i_valid at edge N into an empty buffer -> o_valid high, lane 0 presented, after edge N (cycle N+1). o_count/o_full reflect push/pop one cycle after the edge that caused it.
- Throughput: one word per cycle with i_ready held high; a vector drains in exactly NUM_OLANES cycles; back-to-back vectors produce no bubble between lane NUM_OLANES-1 and the next lane 0.
- Full with simultaneous pop (last lane transferring) and i_valid: push accepted, count stays DEPTH, no overflow.
- Empty with i_valid: push accepted; nothing popped that cycle.
- Overflow flag rises the cycle after the dropping strobe.

## Test plan
- Single vector lanes 0x10..0x17 (NUM_OLANES=8), i_ready=1 -> o_valid cycles 1..8, o_data 0x10..0x17, o_lane 0..7, o_last only on 0x17, o_count 1 then 0.
- Same vector, i_ready toggled 1,0,0,1,... -> every word held stable while stalled; 8 transfers total, order preserved.
- i_ready=0, five strobes with DEPTH=4 -> o_count 4, o_full 1, o_overflow 1 after the 5th; drain yields only vectors 1-4.
- Full buffer, i_valid coincident with last-lane transfer -> push accepted, o_count stays 4, o_overflow stays 0, new vector appears in order.
- Twelve vectors pushed every 8 cycles with i_ready=1 (pointer wrap x3) -> 96 words contiguous, correct order, o_count never exceeds 2.
- rst asserted mid-drain at lane 3 with 2 buffered -> all outputs 0 immediately; next strobe after release streams from lane 0.
